clint_arbiter: RTL and testbench

CLINT_ARBITER -- requirements
Module: clint_arbiter

---
 rtl/clint_arbiter_pkg.sv | 20 ++
 rtl/clint_arbiter_if.sv | 40 ++++
 rtl/clint_arbiter_rr_arb2.sv | 13 +
 rtl/clint_arbiter.sv | 137 +++++++++++++
 tb/tb_clint_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clint_arbiter_pkg.sv
// Shared definitions for the two-master CLINT AXI4-Lite arbiter: FSM state
// encoding, response codes and bus widths.
package clint_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/clint_arbiter_if.sv
// AXI4-Lite bundle for N ports packed side by side; port i owns slice i of
// every field. The masters use N=2, the CLINT side uses N=1.
interface clint_arbiter_if
    import clint_arbiter_pkg::*;
#(
    parameter int N = 1
);
    logic [N*ADDR_W-1:0] araddr;
    logic [N*3-1:0]      arprot;
    logic [N-1:0]        arvalid;
    logic [N-1:0]        arready;
    logic [N*DATA_W-1:0] rdata;
    logic [N*2-1:0]      rresp;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;
    logic [N*ADDR_W-1:0] awaddr;
    logic [N*3-1:0]      awprot;
    logic [N-1:0]        awvalid;
    logic [N-1:0]        awready;
    logic [N*DATA_W-1:0] wdata;
    logic [N*STRB_W-1:0] wstrb;
    logic [N-1:0]        wvalid;
    logic [N-1:0]        wready;
    logic [N*2-1:0]      bresp;
    logic [N-1:0]        bvalid;
    logic [N-1:0]        bready;

    modport master (
        output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
               wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
               wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/clint_arbiter_rr_arb2.sv
// Two-input round-robin picker: the prioritised requester wins, otherwise
// the other one. o_gnt is meaningless when o_any is low.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic       o_gnt,
    output logic       o_any
);

    assign o_any = |i_req;
    assign o_gnt = i_req[i_prio] ? i_prio : ~i_prio;

endmodule

// File: rtl/clint_arbiter.sv
// Serialises two AXI4-Lite masters onto the CLINT slave, one transaction at a
// time, round-robin between masters and write-before-read within a master.
module clint_arbiter
    import clint_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    clint_arbiter_if.slave  m,
    clint_arbiter_if.master s
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_gnt;
    logic       r_prio;
    logic       r_aw_done;
    logic       r_w_done;

    logic [1:0] w_req_rd;
    logic [1:0] w_req_wr;
    logic       w_arb_gnt;
    logic       w_arb_any;
    logic       w_aw_vld;
    logic       w_w_vld;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_wr_last;

    assign w_req_rd = m.arvalid;
    assign w_req_wr = m.awvalid & m.wvalid;

    rr_arb2 u_rr_arb2 (
        .i_req  (w_req_rd | w_req_wr),
        .i_prio (r_prio),
        .o_gnt  (w_arb_gnt),
        .o_any  (w_arb_any)
    );

    // Once one write channel has handshaken, the other is presented alone.
    assign w_aw_vld  = (r_state == WR_ADDR) && !r_aw_done && m.awvalid[r_gnt]
                       && (m.wvalid[r_gnt] || r_w_done);
    assign w_w_vld   = (r_state == WR_ADDR) && !r_w_done && m.wvalid[r_gnt]
                       && (m.awvalid[r_gnt] || r_aw_done);
    assign w_aw_hs   = w_aw_vld && s.awready;
    assign w_w_hs    = w_w_vld && s.wready;
    assign w_wr_last = (r_state == WR_ADDR) && (r_aw_done || w_aw_hs)
                       && (r_w_done || w_w_hs);

    // NOTE: state uses non-blocking assignments and a synchronous reset so every
    // register updates together on the same edge, independent of process order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_gnt     <= 1'b0;
            r_prio    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_arb_any) begin
                r_gnt <= w_arb_gnt;
            end
            if (r_state != IDLE && w_state_nxt == IDLE) begin
                r_prio <= ~r_gnt;
            end
            if (w_wr_last) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;

        s.araddr  = m.araddr[ADDR_W*r_gnt +: ADDR_W];
        s.arprot  = m.arprot[3*r_gnt +: 3];
        s.awaddr  = m.awaddr[ADDR_W*r_gnt +: ADDR_W];
        s.awprot  = m.awprot[3*r_gnt +: 3];
        s.wdata   = m.wdata[DATA_W*r_gnt +: DATA_W];
        s.wstrb   = m.wstrb[STRB_W*r_gnt +: STRB_W];
        s.arvalid = 1'b0;
        s.awvalid = 1'b0;
        s.wvalid  = 1'b0;
        s.rready  = 1'b0;
        s.bready  = 1'b0;

        m.arready = '0;
        m.awready = '0;
        m.wready  = '0;
        m.rvalid  = '0;
        m.bvalid  = '0;
        m.rdata   = '0;
        m.rresp   = {2{RESP_OKAY}};
        m.bresp   = {2{RESP_OKAY}};

        unique case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_state_nxt = w_req_wr[w_arb_gnt] ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                s.arvalid        = m.arvalid[r_gnt];
                m.arready[r_gnt] = s.arready;
                if (m.arvalid[r_gnt] && s.arready) w_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                m.rvalid[r_gnt]                 = s.rvalid;
                m.rdata[DATA_W*r_gnt +: DATA_W] = s.rdata;
                m.rresp[2*r_gnt +: 2]           = s.rresp;
                s.rready                        = m.rready[r_gnt];
                if (s.rvalid && m.rready[r_gnt]) w_state_nxt = IDLE;
            end
            WR_ADDR: begin
                s.awvalid        = w_aw_vld;
                s.wvalid         = w_w_vld;
                m.awready[r_gnt] = w_aw_hs;
                m.wready[r_gnt]  = w_w_hs;
                if (w_wr_last) w_state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m.bvalid[r_gnt]       = s.bvalid;
                m.bresp[2*r_gnt +: 2] = s.bresp;
                s.bready              = m.bready[r_gnt];
                if (s.bvalid && m.bready[r_gnt]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed bench for clint_arbiter: inputs change on the falling edge,
// outputs are compared shortly after, expectations are hand-derived.
module tb_clint_arbiter;
    import clint_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    int aw_hs_cnt = 0;
    int b0_hs_cnt = 0;
    int r1_vld_cnt = 0;

    clint_arbiter_if #(.N(2)) m_if ();
    clint_arbiter_if #(.N(1)) s_if ();

    clint_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .m    (m_if),
        .s    (s_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_if.awvalid[0] && s_if.awready[0]) aw_hs_cnt <= aw_hs_cnt + 1;
        if (m_if.bvalid[0] && m_if.bready[0])   b0_hs_cnt <= b0_hs_cnt + 1;
        if (m_if.rvalid[1])                     r1_vld_cnt <= r1_vld_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_if.araddr = '0; m_if.arprot = '0; m_if.arvalid = '0; m_if.rready = '0;
        m_if.awaddr = '0; m_if.awprot = '0; m_if.awvalid = '0;
        m_if.wdata = '0;  m_if.wstrb = '0;  m_if.wvalid = '0;  m_if.bready = '0;
        s_if.arready = '0; s_if.rdata = '0; s_if.rresp = '0; s_if.rvalid = '0;
        s_if.awready = '0; s_if.wready = '0; s_if.bresp = '0; s_if.bvalid = '0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    // Entered at a falling edge with the FSM in RD_ADDR for master g; leaves it in IDLE.
    task automatic serve_read(input int g, input logic [31:0] addr, input logic [2:0] prot,
                              input logic [31:0] data, input logic [1:0] resp,
                              input bit drop, input string tag);
        logic [1:0] exp_oh;
        exp_oh = (g == 1) ? 2'b10 : 2'b01;
        #1;
        n_tests++; if (s_if.arvalid !== 1'b1) begin n_fail++; $display("FAIL %s_arvalid got %b want 1", tag, s_if.arvalid); end
        n_tests++; if (s_if.araddr !== addr) begin n_fail++; $display("FAIL %s_araddr got %h want %h", tag, s_if.araddr, addr); end
        n_tests++; if (s_if.arprot !== prot) begin n_fail++; $display("FAIL %s_arprot got %b want %b", tag, s_if.arprot, prot); end
        s_if.arready = 1'b1;
        #1;
        n_tests++; if (m_if.arready !== exp_oh) begin n_fail++; $display("FAIL %s_arready got %b want %b", tag, m_if.arready, exp_oh); end
        tick();
        if (drop) m_if.arvalid[g] = 1'b0;
        s_if.arready = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = data; s_if.rresp = resp;
        #1;
        n_tests++; if (m_if.rvalid !== exp_oh) begin n_fail++; $display("FAIL %s_rvalid got %b want %b", tag, m_if.rvalid, exp_oh); end
        n_tests++; if (m_if.rdata[32*g +: 32] !== data) begin n_fail++; $display("FAIL %s_rdata got %h want %h", tag, m_if.rdata[32*g +: 32], data); end
        n_tests++; if (m_if.rdata[32*(1-g) +: 32] !== 32'h0) begin n_fail++; $display("FAIL %s_rdata_other got %h want 0", tag, m_if.rdata[32*(1-g) +: 32]); end
        n_tests++; if (m_if.rresp[2*g +: 2] !== resp) begin n_fail++; $display("FAIL %s_rresp got %b want %b", tag, m_if.rresp[2*g +: 2], resp); end
        n_tests++; if (s_if.rready !== 1'b1) begin n_fail++; $display("FAIL %s_rready got %b want 1", tag, s_if.rready); end
        tick();
        s_if.rvalid = 1'b0;
        #1;
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL %s_idle got %s want IDLE", tag, dut.r_state.name()); end
        n_tests++; if (m_if.rvalid !== 2'b00) begin n_fail++; $display("FAIL %s_rvalid_end got %b want 00", tag, m_if.rvalid); end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m_if.arvalid = 2'b11; m_if.awvalid = 2'b11; m_if.wvalid = 2'b11;
        m_if.rready = 2'b11;  m_if.bready = 2'b11;
        s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
        s_if.rvalid = 1'b1;  s_if.bvalid = 1'b1;
        tick();
        tick();
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rst_state got %s want IDLE", dut.r_state.name()); end
        n_tests++; if (dut.r_prio !== 1'b0) begin n_fail++; $display("FAIL rst_prio got %b want 0", dut.r_prio); end
        n_tests++; if (dut.r_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got %b want 0", dut.r_gnt); end
        n_tests++; if ({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready} !== 5'b0) begin
            n_fail++; $display("FAIL rst_slave_hs got %b want 00000", {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready}); end
        n_tests++; if ({m_if.arready, m_if.awready, m_if.wready, m_if.rvalid, m_if.bvalid} !== 10'b0) begin
            n_fail++; $display("FAIL rst_master_hs got %b want 0", {m_if.arready, m_if.awready, m_if.wready, m_if.rvalid, m_if.bvalid}); end
        clear_inputs();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_read_m0();
        int snap;
        snap = r1_vld_cnt;
        m_if.rready = 2'b11;
        m_if.arvalid = 2'b01; m_if.araddr[31:0] = 32'h0000_bff8; m_if.arprot[2:0] = 3'b001;
        #1;
        n_tests++; if (s_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL rd0_idle_arvalid got %b want 0", s_if.arvalid); end
        tick();
        serve_read(0, 32'h0000_bff8, 3'b001, 32'hdead_beef, RESP_OKAY, 1'b1, "rd0");
        n_tests++; if (dut.r_prio !== 1'b1) begin n_fail++; $display("FAIL rd0_prio got %b want 1", dut.r_prio); end
        tick();
        n_tests++; if (r1_vld_cnt - snap !== 0) begin n_fail++; $display("FAIL rd0_m1_rvalid got %0d want 0", r1_vld_cnt - snap); end
    endtask

    task automatic test_back_to_back();
        int exp_gnt [4] = '{0, 1, 0, 1};
        logic [31:0] addr_tab [2] = '{32'h0000_0100, 32'h0000_0200};
        logic [2:0]  prot_tab [2] = '{3'b001, 3'b110};
        pulse_reset();
        m_if.rready = 2'b11;
        m_if.araddr = {addr_tab[1], addr_tab[0]};
        m_if.arprot = {prot_tab[1], prot_tab[0]};
        m_if.arvalid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (s_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_arvalid[%0d] got %b want 0", i, s_if.arvalid); end
            tick();
            n_tests++; if (dut.r_gnt !== exp_gnt[i][0]) begin n_fail++; $display("FAIL b2b_gnt[%0d] got %b want %0d", i, dut.r_gnt, exp_gnt[i]); end
            serve_read(exp_gnt[i], addr_tab[exp_gnt[i]], prot_tab[exp_gnt[i]], 32'h1000 + i, RESP_OKAY, 1'b0, "b2b");
        end
        m_if.arvalid = 2'b00;
        tick();
    endtask

    task automatic test_write_first();
        m_if.rready = 2'b11; m_if.bready = 2'b11;
        m_if.awaddr[63:32] = 32'h0000_4000; m_if.awprot[5:3] = 3'b010;
        m_if.wdata[63:32] = 32'h1234_5678;  m_if.wstrb[7:4] = 4'b0011;
        m_if.araddr[63:32] = 32'h0000_4004; m_if.arprot[5:3] = 3'b100;
        m_if.awvalid = 2'b10; m_if.wvalid = 2'b10; m_if.arvalid = 2'b10;
        tick();
        n_tests++; if (dut.r_state !== WR_ADDR) begin n_fail++; $display("FAIL wf_state got %s want WR_ADDR", dut.r_state.name()); end
        n_tests++; if ({s_if.awvalid, s_if.wvalid, s_if.arvalid} !== 3'b110) begin
            n_fail++; $display("FAIL wf_valids got %b want 110", {s_if.awvalid, s_if.wvalid, s_if.arvalid}); end
        n_tests++; if (s_if.awaddr !== 32'h0000_4000) begin n_fail++; $display("FAIL wf_awaddr got %h want 00004000", s_if.awaddr); end
        n_tests++; if (s_if.awprot !== 3'b010) begin n_fail++; $display("FAIL wf_awprot got %b want 010", s_if.awprot); end
        n_tests++; if (s_if.wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wf_wdata got %h want 12345678", s_if.wdata); end
        n_tests++; if (s_if.wstrb !== 4'b0011) begin n_fail++; $display("FAIL wf_wstrb got %b want 0011", s_if.wstrb); end
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        #1;
        n_tests++; if ({m_if.awready, m_if.wready} !== 4'b1010) begin
            n_fail++; $display("FAIL wf_readies got %b want 1010", {m_if.awready, m_if.wready}); end
        tick();
        m_if.awvalid = 2'b00; m_if.wvalid = 2'b00;
        s_if.awready = 1'b0; s_if.wready = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = RESP_OKAY;
        #1;
        n_tests++; if (m_if.bvalid !== 2'b10) begin n_fail++; $display("FAIL wf_bvalid got %b want 10", m_if.bvalid); end
        n_tests++; if (s_if.bready !== 1'b1) begin n_fail++; $display("FAIL wf_bready got %b want 1", s_if.bready); end
        n_tests++; if (s_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL wf_read_early got %b want 0", s_if.arvalid); end
        tick();
        s_if.bvalid = 1'b0;
        #1;
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL wf_idle got %s want IDLE", dut.r_state.name()); end
        tick();
        serve_read(1, 32'h0000_4004, 3'b100, 32'h0bad_cafe, RESP_OKAY, 1'b1, "wf_rd");
        tick();
    endtask

    task automatic test_split_write();
        int aw_snap, b_snap;
        aw_snap = aw_hs_cnt; b_snap = b0_hs_cnt;
        m_if.bready = 2'b11;
        m_if.awaddr[31:0] = 32'h0000_4008; m_if.wdata[31:0] = 32'hcafe_f00d; m_if.wstrb[3:0] = 4'b1111;
        m_if.awvalid = 2'b01; m_if.wvalid = 2'b01;
        tick();
        s_if.awready = 1'b1; s_if.wready = 1'b0;
        #1;
        n_tests++; if ({m_if.awready, m_if.wready} !== 4'b0100) begin
            n_fail++; $display("FAIL sw_aw_first got %b want 0100", {m_if.awready, m_if.wready}); end
        tick();
        m_if.awvalid = 2'b00;
        s_if.wready = 1'b1;
        #1;
        n_tests++; if (dut.r_aw_done !== 1'b1) begin n_fail++; $display("FAIL sw_aw_done got %b want 1", dut.r_aw_done); end
        n_tests++; if ({s_if.awvalid, s_if.wvalid} !== 2'b01) begin
            n_fail++; $display("FAIL sw_w_alone got %b want 01", {s_if.awvalid, s_if.wvalid}); end
        n_tests++; if ({m_if.awready, m_if.wready} !== 4'b0001) begin
            n_fail++; $display("FAIL sw_w_ready got %b want 0001", {m_if.awready, m_if.wready}); end
        tick();
        m_if.wvalid = 2'b00;
        s_if.awready = 1'b0; s_if.wready = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = RESP_OKAY;
        #1;
        n_tests++; if (dut.r_state !== WR_RESP) begin n_fail++; $display("FAIL sw_state got %s want WR_RESP", dut.r_state.name()); end
        n_tests++; if (m_if.bvalid !== 2'b01) begin n_fail++; $display("FAIL sw_bvalid got %b want 01", m_if.bvalid); end
        tick();
        s_if.bvalid = 1'b0;
        #1;
        n_tests++; if (m_if.bvalid !== 2'b00) begin n_fail++; $display("FAIL sw_bvalid_end got %b want 00", m_if.bvalid); end
        tick();
        n_tests++; if (aw_hs_cnt - aw_snap !== 1) begin n_fail++; $display("FAIL sw_aw_count got %0d want 1", aw_hs_cnt - aw_snap); end
        n_tests++; if (b0_hs_cnt - b_snap !== 1) begin n_fail++; $display("FAIL sw_b_count got %0d want 1", b0_hs_cnt - b_snap); end
    endtask

    task automatic test_slverr();
        m_if.rready = 2'b11;
        m_if.araddr[31:0] = 32'h0000_1234; m_if.arprot[2:0] = 3'b000;
        m_if.arvalid = 2'b01;
        tick();
        serve_read(0, 32'h0000_1234, 3'b000, 32'h0, RESP_SLVERR, 1'b1, "slverr");
        n_tests++; if (dut.r_prio !== 1'b1) begin n_fail++; $display("FAIL slverr_prio got %b want 1", dut.r_prio); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        m_if.rready = 2'b11;
        m_if.araddr[31:0] = 32'h0000_2008; m_if.arvalid = 2'b01;
        tick();
        s_if.arready = 1'b1;
        tick();
        m_if.arvalid = 2'b00; s_if.arready = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_0055;
        #1;
        n_tests++; if (m_if.rvalid !== 2'b01) begin n_fail++; $display("FAIL rmr_inflight got %b want 01", m_if.rvalid); end
        rstn = 1'b0;
        tick();
        #1;
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rmr_state got %s want IDLE", dut.r_state.name()); end
        n_tests++; if (dut.r_prio !== 1'b0) begin n_fail++; $display("FAIL rmr_prio got %b want 0", dut.r_prio); end
        n_tests++; if ({m_if.rvalid, s_if.arvalid, s_if.rready} !== 4'b0) begin
            n_fail++; $display("FAIL rmr_valids got %b want 0000", {m_if.rvalid, s_if.arvalid, s_if.rready}); end
        rstn = 1'b1;
        s_if.rvalid = 1'b0;
        m_if.araddr[63:32] = 32'h0000_2000; m_if.arprot[5:3] = 3'b000; m_if.arvalid = 2'b10;
        tick();
        serve_read(1, 32'h0000_2000, 3'b000, 32'h7777_0001, RESP_OKAY, 1'b1, "rmr_m1");
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_read_m0();
        test_back_to_back();
        test_write_first();
        test_split_write();
        test_slverr();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
